// File: rtl/rip_bp_update_queue.sv
// In-order queue of branch-predictor state for branches in flight between fetch and execute.
// Drives the predictor update port one cycle after each resolve and flags mispredicts.
module rip_bp_update_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned INDEX_W  = 10,
    parameter int unsigned WEIGHT_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [INDEX_W-1:0]         push_index,
    input  logic [WEIGHT_W-1:0]        push_weight,
    input  logic                       push_pred,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    input  logic                       flush,
    output logic                       update,
    output logic [INDEX_W-1:0]         update_index,
    output logic [WEIGHT_W-1:0]        update_weight,
    output logic                       actual,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       err_underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = INDEX_W + WEIGHT_W + 1;

    logic [ENT_W-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                update_q, mispredict_q, actual_q, err_q;
    logic [INDEX_W-1:0]  upd_index_q;
    logic [WEIGHT_W-1:0] upd_weight_q;

    logic                do_push, do_pop;
    logic [ENT_W-1:0]    head;
    logic [INDEX_W-1:0]  head_index;
    logic [WEIGHT_W-1:0] head_weight;
    logic                head_pred;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign push_ready = ~full;
    assign count      = count_q;

    assign do_push = push_valid & ~full & ~flush;
    assign do_pop  = resolve_valid & ~empty;

    assign head = mem_q[rd_ptr_q];
    assign {head_index, head_weight, head_pred} = head;

    // Flush discards everything after the same-cycle pop: read pointer jumps to the
    // (unadvanced) write pointer since any same-cycle push is dropped.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= {push_index, push_weight, push_pred};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            update_q     <= 1'b0;
            mispredict_q <= 1'b0;
            actual_q     <= 1'b0;
            err_q        <= 1'b0;
            upd_index_q  <= '0;
            upd_weight_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            update_q     <= do_pop;
            mispredict_q <= do_pop & (head_pred ^ resolve_taken);
            if (do_pop) begin
                upd_index_q  <= head_index;
                upd_weight_q <= head_weight;
                actual_q     <= resolve_taken;
            end
            if (resolve_valid & empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign update        = update_q;
    assign mispredict    = mispredict_q;
    assign actual        = actual_q;
    assign update_index  = upd_index_q;
    assign update_weight = upd_weight_q;
    assign err_underflow = err_q;

endmodule
